// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation codes and the latched decode record.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_XOR  = 4'b1101;

    typedef enum logic [2:0] {
        CLS_ILL = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_LW  = 3'd3,
        CLS_SW  = 3'd4,
        CLS_BEQ = 3'd5
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   alu_ctrl;
        logic         alu_src;
        logic         mem_to_reg;
    } decode_t;

    // Any encoding the ALU decoder rejects collapses to the illegal class.
    function automatic instr_class_t classify(input logic [6:0] opcode, input logic legal);
        instr_class_t c;
        if (!legal) begin
            c = CLS_ILL;
        end else begin
            case (opcode)
                OP_R:    c = CLS_R;
                OP_I:    c = CLS_I;
                OP_LW:   c = CLS_LW;
                OP_SW:   c = CLS_SW;
                OP_BEQ:  c = CLS_BEQ;
                default: c = CLS_ILL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder: opcode/funct3/funct7 to ALU operation
// code plus a legality flag for the supported RV32I subset.
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    // Operation select and legality check.
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  alu_ctrl = ALU_ADD;
                        3'b001:  alu_ctrl = ALU_SLL;
                        3'b010:  alu_ctrl = ALU_SLT;
                        3'b011:  alu_ctrl = ALU_SLTU;
                        3'b100:  alu_ctrl = ALU_XOR;
                        3'b101:  alu_ctrl = ALU_SRL;
                        3'b110:  alu_ctrl = ALU_OR;
                        3'b111:  alu_ctrl = ALU_AND;
                        default: legal    = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  begin alu_ctrl = ALU_SUB; legal = 1'b1; end
                        3'b101:  begin alu_ctrl = ALU_SRA; legal = 1'b1; end
                        default: legal = 1'b0;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
                    3'b010: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
                    3'b100: begin alu_ctrl = ALU_XOR; legal = 1'b1; end
                    3'b110: begin alu_ctrl = ALU_OR;  legal = 1'b1; end
                    3'b111: begin alu_ctrl = ALU_AND; legal = 1'b1; end
                    3'b001: begin alu_ctrl = ALU_SLL; legal = (funct7 == 7'b0000000); end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            alu_ctrl = ALU_SRL;
                            legal    = 1'b1;
                        end else if (funct7 == 7'b0100000) begin
                            alu_ctrl = ALU_SRA;
                            legal    = 1'b1;
                        end else begin
                            legal    = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW:   legal = (funct3 == 3'b010);
            OP_SW:   legal = (funct3 == 3'b010);
            OP_BEQ:  begin alu_ctrl = ALU_SUB; legal = (funct3 == 3'b000); end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I datapath (IF->ID->EX->[MEM]->WB).
// Optional PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        dmem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  state,
    output logic        illegal_instr,
    output logic        mem_timeout
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        state_r, state_nxt_s;
    decode_t       dec_r, dec_now_s, dec_s;
    instr_class_t  cls_now_s;
    logic [3:0]    dec_alu_s;
    logic          dec_legal_s;
    logic [CW-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic          tmo_s;
    logic          pcsrc_nxt_s, alusrc_nxt_s, regwrite_nxt_s, memtoreg_nxt_s;
    logic          loadpc_nxt_s, memread_nxt_s, memwrite_nxt_s, illegal_nxt_s, tmo_nxt_s;
    logic [3:0]    aluctrl_nxt_s;
    logic          unused_instr_s;

    alu_decoder u_alu_decoder (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7   (instr[31:25]),
        .alu_ctrl (dec_alu_s),
        .legal    (dec_legal_s)
    );

    assign unused_instr_s = ^{instr[24:15], instr[11:7]};
    assign cls_now_s      = classify(instr[6:0], dec_legal_s);
    assign state          = state_r;

    // Fresh decode of the current instruction word.
    always_comb begin
        dec_now_s.cls        = cls_now_s;
        dec_now_s.alu_ctrl   = dec_alu_s;
        dec_now_s.alu_src    = (cls_now_s == CLS_I) || (cls_now_s == CLS_LW) || (cls_now_s == CLS_SW);
        dec_now_s.mem_to_reg = (cls_now_s == CLS_LW);
    end

    // Outputs for EX are registered at the end of ID, before dec_r is loaded.
    always_comb begin
        if (state_r == S_ID) begin
            dec_s = dec_now_s;
        end else begin
            dec_s = dec_r;
        end
    end

    // Next-state logic and MEM wait/timeout tracking.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = {CW{1'b0}};
        tmo_s          = 1'b0;
        case (state_r)
            S_IF: state_nxt_s = S_ID;
            S_ID: state_nxt_s = S_EX;
            S_EX: begin
                if ((dec_r.cls == CLS_LW) || (dec_r.cls == CLS_SW)) begin
                    state_nxt_s = S_MEM;
                end else begin
                    state_nxt_s = S_WB;
                end
            end
            S_MEM: begin
                // Ready on the final allowed cycle still completes normally.
                if (dmem_ready) begin
                    state_nxt_s = S_WB;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_r == CW'(MEM_TIMEOUT - 1))) begin
                    state_nxt_s = S_WB;
                    tmo_s       = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + CW'(1);
                end
            end
            S_WB:    state_nxt_s = S_IF;
            default: state_nxt_s = S_IF;
        endcase
    end

    // Output values for the state about to be entered.
    always_comb begin
        pcsrc_nxt_s    = 1'b0;
        alusrc_nxt_s   = 1'b0;
        regwrite_nxt_s = 1'b0;
        memtoreg_nxt_s = 1'b0;
        aluctrl_nxt_s  = ALU_ADD;
        loadpc_nxt_s   = 1'b0;
        memread_nxt_s  = 1'b0;
        memwrite_nxt_s = 1'b0;
        illegal_nxt_s  = 1'b0;
        tmo_nxt_s      = 1'b0;
        case (state_nxt_s)
            S_EX: begin
                aluctrl_nxt_s = dec_s.alu_ctrl;
                alusrc_nxt_s  = dec_s.alu_src;
                illegal_nxt_s = (dec_s.cls == CLS_ILL);
            end
            S_MEM: begin
                aluctrl_nxt_s  = dec_s.alu_ctrl;
                alusrc_nxt_s   = dec_s.alu_src;
                memread_nxt_s  = (dec_s.cls == CLS_LW);
                memwrite_nxt_s = (dec_s.cls == CLS_SW);
            end
            S_WB: begin
                // zero is only meaningful here when arriving straight from EX.
                aluctrl_nxt_s  = dec_s.alu_ctrl;
                alusrc_nxt_s   = dec_s.alu_src;
                loadpc_nxt_s   = 1'b1;
                pcsrc_nxt_s    = (dec_s.cls == CLS_BEQ) && (state_r == S_EX) && zero;
                regwrite_nxt_s = (dec_s.cls inside {CLS_R, CLS_I, CLS_LW}) && !tmo_s;
                memtoreg_nxt_s = dec_s.mem_to_reg;
                tmo_nxt_s      = tmo_s;
            end
            default: begin
                aluctrl_nxt_s = ALU_ADD;
            end
        endcase
    end

    // State, latched decode, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IF;
            dec_r         <= '{cls: CLS_ILL, alu_ctrl: ALU_ADD, alu_src: 1'b0, mem_to_reg: 1'b0};
            wait_cnt_r    <= {CW{1'b0}};
            PCSrc         <= 1'b0;
            ALUSrc        <= 1'b0;
            RegWrite      <= 1'b0;
            MemToReg      <= 1'b0;
            ALUCtrl       <= ALU_ADD;
            loadPC        <= 1'b0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            illegal_instr <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_ID) begin
                dec_r <= dec_now_s;
            end else begin
                dec_r <= dec_r;
            end
            wait_cnt_r    <= wait_cnt_nxt_s;
            PCSrc         <= pcsrc_nxt_s;
            ALUSrc        <= alusrc_nxt_s;
            RegWrite      <= regwrite_nxt_s;
            MemToReg      <= memtoreg_nxt_s;
            ALUCtrl       <= aluctrl_nxt_s;
            loadPC        <= loadpc_nxt_s;
            MemRead       <= memread_nxt_s;
            MemWrite      <= memwrite_nxt_s;
            illegal_instr <= illegal_nxt_s;
            mem_timeout   <= tmo_nxt_s;
        end
    end

`ifdef PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state_r == S_WB) begin
                instret_cnt <= instret_cnt + 32'd1;
            end else begin
                instret_cnt <= instret_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (MEM_TIMEOUT=4).
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic        zero = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
    logic        illegal_instr, mem_timeout;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    int          ref_cyc = 0;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        int         cyc;
        int         mask;
        int         memreq;
        logic       rw, m2r, pcs, src, tmo, ill;
        logic [3:0] alu;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ready(dmem_ready),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .state(state), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

`ifdef PERF_CNT_EN
    always @(posedge clk) begin
        if (rst) ref_cyc <= 0;
        else     ref_cyc <= ref_cyc + 1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input string tag, input int cyc, input int mask, input int memreq,
                                input logic rw, input logic m2r, input logic pcs, input logic src,
                                input logic tmo, input logic ill, input logic [3:0] alu);
        exp_t e;
        e.tag = tag; e.cyc = cyc; e.mask = mask; e.memreq = memreq;
        e.rw = rw; e.m2r = m2r; e.pcs = pcs; e.src = src; e.tmo = tmo; e.ill = ill; e.alu = alu;
        return e;
    endfunction

    // Runs one instruction from an IF-cycle negedge to the next IF-cycle negedge.
    // ready_after: MEM cycles without ready before ready is given (-1 = never).
    task automatic run(input exp_t e, input logic [31:0] ins, input logic z,
                       input int ready_after, input logic noisy);
        int cyc = 0, mask = 0, memreq = 0, memcyc = 0;
        logic ill = 1'b0, done = 1'b0;
        logic rw = 1'b0, m2r = 1'b0, pcs = 1'b0, src = 1'b0, tmo = 1'b0, lpc = 1'b0, mreq = 1'b0;
        logic [3:0] alu = 4'd0;
        exp_t x;
        instr = ins;
        zero  = z;
        sb.push_back(e);
        for (int k = 0; k < 40 && !done; k++) begin
            cyc++;
            mask |= (1 << state);
            if (illegal_instr) ill = 1'b1;
            if (state == 3'd3) begin
                memcyc++;
                if (MemRead || MemWrite) memreq++;
                dmem_ready = (ready_after >= 0) && (memcyc == ready_after + 1);
            end else begin
                dmem_ready = noisy;
            end
            if (state == 3'd4) begin
                rw = RegWrite; m2r = MemToReg; pcs = PCSrc; src = ALUSrc; tmo = mem_timeout;
                alu = ALUCtrl; lpc = loadPC; mreq = MemRead | MemWrite;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check({e.tag, ".reached_wb"}, 32'(done), 32'd1);
        x = sb.pop_front();
        check({x.tag, ".cycles"},   32'(cyc),    32'(x.cyc));
        check({x.tag, ".states"},   32'(mask),   32'(x.mask));
        check({x.tag, ".memreq"},   32'(memreq), 32'(x.memreq));
        check({x.tag, ".RegWrite"}, 32'(rw),     32'(x.rw));
        check({x.tag, ".MemToReg"}, 32'(m2r),    32'(x.m2r));
        check({x.tag, ".PCSrc"},    32'(pcs),    32'(x.pcs));
        check({x.tag, ".ALUSrc"},   32'(src),    32'(x.src));
        check({x.tag, ".ALUCtrl"},  32'(alu),    32'(x.alu));
        check({x.tag, ".timeout"},  32'(tmo),    32'(x.tmo));
        check({x.tag, ".illegal"},  32'(ill),    32'(x.ill));
        check({x.tag, ".loadPC"},   32'(lpc),    32'd1);
        check({x.tag, ".wb_memreq"}, 32'(mreq),  32'd0);
        @(negedge clk);
        dmem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst.state",    32'(state),   32'd0);
        check("rst.ALUCtrl",  32'(ALUCtrl), 32'b0010);
        check("rst.strobes",  32'({PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite,
                                   illegal_instr, mem_timeout}), 32'd0);
        rst = 1'b0;

        //            tag          cyc mask  mreq rw m2r pcs src tmo ill alu
        run(mk("add",   4, 'h17, 0, 1, 0, 0, 0, 0, 0, 4'b0010), 32'h002081B3, 1'b0, -1, 1'b0);
        run(mk("addi",  4, 'h17, 0, 1, 0, 0, 1, 0, 0, 4'b0010), 32'h00500093, 1'b0, -1, 1'b0);
        run(mk("sub",   4, 'h17, 0, 1, 0, 0, 0, 0, 0, 4'b0110), 32'h402081B3, 1'b1, -1, 1'b0);
        run(mk("sra",   4, 'h17, 0, 1, 0, 0, 0, 0, 0, 4'b1010), 32'h4020D1B3, 1'b0, -1, 1'b0);
        run(mk("beq_t", 4, 'h17, 0, 0, 0, 1, 0, 0, 0, 4'b0110), 32'h00208063, 1'b1, -1, 1'b0);
        run(mk("beq_n", 4, 'h17, 0, 0, 0, 0, 0, 0, 0, 4'b0110), 32'h00208063, 1'b0, -1, 1'b0);
        run(mk("lw_w3", 8, 'h1F, 4, 1, 1, 0, 1, 0, 0, 4'b0010), 32'h0080A283, 1'b0,  3, 1'b1);
        run(mk("lw_w0", 5, 'h1F, 1, 1, 1, 0, 1, 0, 0, 4'b0010), 32'h0080A283, 1'b0,  0, 1'b0);
        run(mk("sw_to", 8, 'h1F, 4, 0, 0, 0, 1, 1, 0, 4'b0010), 32'h0020A223, 1'b0, -1, 1'b0);
        run(mk("lw_to", 8, 'h1F, 4, 0, 1, 0, 1, 1, 0, 4'b0010), 32'h0080A283, 1'b0, -1, 1'b0);
        run(mk("op7f",  4, 'h17, 0, 0, 0, 0, 0, 0, 1, 4'b0010), 32'h0000007F, 1'b1, -1, 1'b0);
        run(mk("sltiu", 4, 'h17, 0, 0, 0, 0, 0, 0, 1, 4'b0010), 32'h00103093, 1'b0, -1, 1'b0);

`ifdef PERF_CNT_EN
        check("perf.instret", instret_cnt, 32'd12);
        check("perf.cycles",  cycle_cnt,   32'(ref_cyc));
`endif

        // Abort a load in its second MEM cycle.
        instr = 32'h0080A283;
        zero = 1'b0;
        dmem_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.in_mem",  32'(state),   32'd3);
        check("abort.memread", 32'(MemRead), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort.state",    32'(state),    32'd0);
        check("abort.memread",  32'(MemRead),  32'd0);
        check("abort.regwrite", 32'(RegWrite), 32'd0);
        check("abort.loadpc",   32'(loadPC),   32'd0);
`ifdef PERF_CNT_EN
        check("abort.cycle_cnt",   cycle_cnt,   32'd0);
        check("abort.instret_cnt", instret_cnt, 32'd0);
`endif
        rst = 1'b0;
        run(mk("add2", 4, 'h17, 0, 1, 0, 0, 0, 0, 0, 4'b0010), 32'h002081B3, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
